// File: rtl/display_pkg.sv
// Shared register map, FIFO entry format and FSM encoding for the LCD writer.
package display_pkg;

  localparam int unsigned ADDR_CMD    = 0;
  localparam int unsigned ADDR_PIX    = 1;
  localparam int unsigned ADDR_CTRL   = 2;
  localparam int unsigned ADDR_STATUS = 3;

  localparam int unsigned CTRL_RST_BIT     = 0;
  localparam int unsigned CTRL_BL_BIT      = 1;
  localparam int unsigned CTRL_OVF_CLR_BIT = 31;

  typedef struct packed {
    logic        is_pix;
    logic [31:0] data;
  } lcd_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobeLo,
    StStrobeHi
  } lcd_state_e;

endpackage

// File: rtl/display_sync_fifo.sv
// Synchronous show-ahead FIFO; a push while full is accepted only if a pop frees a slot.
module display_sync_fifo #(
  parameter int unsigned Width     = 33,
  parameter int unsigned DepthLog2 = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [Width-1:0]     wdata_i,
  input  logic                 pop_i,
  output logic [Width-1:0]     rdata_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [DepthLog2:0]   level_o
);
  localparam int unsigned Depth = 2 ** DepthLog2;

  logic [Width-1:0]     mem_q [Depth];
  logic [DepthLog2-1:0] wptr_q, rptr_q;
  logic [DepthLog2:0]   count_q;
  logic                 do_push, do_pop;

  assign full_o  = (count_q == (DepthLog2 + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + DepthLog2'(1);
      if (do_pop)  rptr_q <= rptr_q + DepthLog2'(1);
      count_q <= count_q + (DepthLog2 + 1)'(do_push) - (DepthLog2 + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign level_o = count_q;

endmodule

// File: rtl/display_lcd_writer.sv
// 8080-style LCD write engine: register decode, command/pixel FIFO and strobe timing FSM.
module display_lcd_writer
  import display_pkg::*;
#(
  parameter int unsigned AW         = 8,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WR_LOW     = 2,
  parameter int unsigned WR_HIGH    = 2
) (
  input  logic          c125,
  input  logic          reset,
  input  logic          wvalid,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic [15:0]   lcd_d,
  output logic          lcd_dc,
  output logic          lcd_wr_n,
  output logic          lcd_cs_n,
  output logic          lcd_rst_n,
  output logic          lcd_bl
);
  localparam int unsigned WrMax = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
  localparam int unsigned CW    = $clog2(WrMax) + 1;

  lcd_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  lcd_entry_t          ent_q, ent_d, push_ent, fifo_ent;
  logic                half_q, half_d;
  logic [15:0]         lcd_d_q, lcd_d_d;
  logic                lcd_dc_q, lcd_dc_d, wr_n_q, wr_n_d, cs_n_q, cs_n_d;
  logic                rst_n_q, bl_q, overflow_q;
  logic [31:0]         rdata_q, rdata_d;
  logic                is_pix_wr, push, pop, second, ctrl_wr, busy;
  logic                fifo_full, fifo_empty;
  logic [DEPTH_LOG2:0] fifo_level;

  assign is_pix_wr     = (addr == AW'(ADDR_PIX));
  assign push          = wvalid && (is_pix_wr || addr == AW'(ADDR_CMD));
  assign ctrl_wr       = wvalid && (addr == AW'(ADDR_CTRL));
  assign push_ent.is_pix = is_pix_wr;
  assign push_ent.data   = is_pix_wr ? wdata : {24'h0, wdata[7:0]};

  display_sync_fifo #(
    .Width    ($bits(lcd_entry_t)),
    .DepthLog2(DEPTH_LOG2)
  ) u_fifo (
    .clk_i  (c125),
    .rst_i  (reset),
    .push_i (push),
    .wdata_i(push_ent),
    .pop_i  (pop),
    .rdata_o(fifo_ent),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .level_o(fifo_level)
  );

  // State register; bus outputs are registered alongside so they change with the state.
  always_ff @(posedge c125) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ent_q    <= '0;
      half_q   <= 1'b0;
      lcd_d_q  <= '0;
      lcd_dc_q <= 1'b0;
      wr_n_q   <= 1'b1;
      cs_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ent_q    <= ent_d;
      half_q   <= half_d;
      lcd_d_q  <= lcd_d_d;
      lcd_dc_q <= lcd_dc_d;
      wr_n_q   <= wr_n_d;
      cs_n_q   <= cs_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    second  = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = StStrobeLo;
      end
      StStrobeLo: begin
        if (cnt_q == CW'(WR_LOW - 1)) begin
          cnt_d   = '0;
          state_d = StStrobeHi;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StStrobeHi: begin
        if (cnt_q == CW'(WR_HIGH - 1)) begin
          cnt_d = '0;
          if (half_q) begin
            second  = 1'b1;
            state_d = StStrobeLo;
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = StSetup;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ent_d    = ent_q;
    half_d   = half_q;
    lcd_d_d  = lcd_d_q;
    lcd_dc_d = lcd_dc_q;
    if (pop) begin
      ent_d    = fifo_ent;
      half_d   = fifo_ent.is_pix;
      lcd_dc_d = fifo_ent.is_pix;
      lcd_d_d  = fifo_ent.is_pix ? fifo_ent.data[31:16] : {8'h00, fifo_ent.data[7:0]};
    end else if (second) begin
      half_d  = 1'b0;
      lcd_d_d = ent_q.data[15:0];
    end
    wr_n_d = (state_d != StStrobeLo);
    cs_n_d = (state_d == StIdle);
  end

  assign busy = (state_q != StIdle) || !fifo_empty;

  always_comb begin
    rdata_d = '0;
    if (addr == AW'(ADDR_CTRL)) begin
      rdata_d = {30'b0, bl_q, rst_n_q};
    end else if (addr == AW'(ADDR_STATUS)) begin
      rdata_d = {overflow_q, busy, 24'b0, 6'(fifo_level)};
    end
  end

  always_ff @(posedge c125) begin
    if (reset) begin
      rst_n_q    <= 1'b0;
      bl_q       <= 1'b0;
      overflow_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rdata_q <= rdata_d;
      if (ctrl_wr) begin
        rst_n_q <= wdata[CTRL_RST_BIT];
        bl_q    <= wdata[CTRL_BL_BIT];
      end
      if (ctrl_wr && wdata[CTRL_OVF_CLR_BIT]) begin
        overflow_q <= 1'b0;
      end else if (push && fifo_full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign rdata     = rdata_q;
  assign lcd_d     = lcd_d_q;
  assign lcd_dc    = lcd_dc_q;
  assign lcd_wr_n  = wr_n_q;
  assign lcd_cs_n  = cs_n_q;
  assign lcd_rst_n = rst_n_q;
  assign lcd_bl    = bl_q;

endmodule

// File: tb/tb_display_lcd_writer.sv
// Bench for display_lcd_writer: bus monitor captures latched words; tasks compare against a
// queue/arithmetic model of the register map, FIFO capacity and strobe timing.
module tb_display_lcd_writer;
  import display_pkg::*;

  localparam int unsigned AW         = 8;
  localparam int unsigned DEPTH_LOG2 = 4;
  localparam int unsigned WR_LOW     = 2;
  localparam int unsigned WR_HIGH    = 2;
  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
  localparam int unsigned PIX_PERIOD = 1 + 2 * (WR_LOW + WR_HIGH);
  localparam int unsigned CMD_SPAN   = 1 + WR_LOW + WR_HIGH;

  logic          c125 = 1'b0;
  logic          reset = 1'b1;
  logic          wvalid = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic [15:0]   lcd_d;
  logic          lcd_dc, lcd_wr_n, lcd_cs_n, lcd_rst_n, lcd_bl;

  int n_checks = 0;
  int n_fails  = 0;

  display_lcd_writer #(
    .AW        (AW),
    .DEPTH_LOG2(DEPTH_LOG2),
    .WR_LOW    (WR_LOW),
    .WR_HIGH   (WR_HIGH)
  ) dut (
    .c125     (c125),
    .reset    (reset),
    .wvalid   (wvalid),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .lcd_d    (lcd_d),
    .lcd_dc   (lcd_dc),
    .lcd_wr_n (lcd_wr_n),
    .lcd_cs_n (lcd_cs_n),
    .lcd_rst_n(lcd_rst_n),
    .lcd_bl   (lcd_bl)
  );

  always #4 c125 = ~c125;

  // Panel model: a word is latched on each rising edge of lcd_wr_n.
  logic [16:0] cap_q[$];
  int          lo_q[$];
  int          hi_q[$];
  logic        prev_wr = 1'b1;
  int          lo_run = 0, hi_run = 0, hi_gap = 0;
  logic [16:0] last_bus = '0;

  always @(negedge c125) begin
    if (!lcd_wr_n) begin
      if (prev_wr) begin
        hi_gap = hi_run;
        lo_run = 0;
      end
      lo_run++;
      last_bus = {lcd_dc, lcd_d};
    end else begin
      if (!prev_wr) begin
        cap_q.push_back(last_bus);
        lo_q.push_back(lo_run);
        hi_q.push_back(hi_gap);
        hi_run = 0;
      end
      hi_run++;
    end
    prev_wr = lcd_wr_n;
  end

  task automatic tick();
    @(posedge c125);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    addr = a; wdata = d; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [31:0] d);
    addr = a; wvalid = 1'b0;
    tick();
    d = rdata;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    addr = AW'(ADDR_STATUS); wvalid = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!rdata[30]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic flush_capture();
    cap_q.delete(); lo_q.delete(); hi_q.delete();
  endtask

  task automatic test_reset();
    logic [31:0] st;
    reset = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({lcd_wr_n, lcd_cs_n, lcd_rst_n, lcd_bl, lcd_dc, lcd_d, rdata} !== {4'b1100, 1'b0, 48'h0}) begin
      n_fails++;
      $display("FAIL reset_outputs: got wr_n=%b cs_n=%b rst_n=%b bl=%b dc=%b d=%h rdata=%h, want 1 1 0 0 0 0000 0",
               lcd_wr_n, lcd_cs_n, lcd_rst_n, lcd_bl, lcd_dc, lcd_d, rdata);
    end
    reset = 1'b0;
    rd(AW'(ADDR_STATUS), st);
    n_checks++;
    if (st !== 32'h0) begin
      n_fails++;
      $display("FAIL reset_status: got %h want 00000000", st);
    end
  endtask

  task automatic test_ctrl();
    logic [31:0] st;
    wr(AW'(ADDR_CTRL), 32'h0000_0003);
    n_checks++;
    if ({lcd_rst_n, lcd_bl} !== 2'b11) begin
      n_fails++;
      $display("FAIL ctrl_pins: got rst_n=%b bl=%b want 1 1", lcd_rst_n, lcd_bl);
    end
    rd(AW'(ADDR_CTRL), st);
    n_checks++;
    if (st !== 32'h3) begin
      n_fails++;
      $display("FAIL ctrl_read: got %h want 00000003", st);
    end
    wr(AW'(ADDR_CTRL), 32'h0000_0002);
    rd(AW'(ADDR_CTRL), st);
    n_checks++;
    if (st !== 32'h2 || lcd_rst_n !== 1'b0 || lcd_bl !== 1'b1) begin
      n_fails++;
      $display("FAIL ctrl_read2: got %h rst_n=%b bl=%b want 00000002 0 1", st, lcd_rst_n, lcd_bl);
    end
    wr(AW'(ADDR_CTRL), 32'h0000_0003);
  endtask

  task automatic test_cmd();
    logic [9:0] act_cs, act_wr, exp_cs, exp_wr;
    logic [16:0] bus3;
    bit ok;
    flush_capture();
    addr = AW'(ADDR_CMD); wdata = {24'($urandom), 8'h2C}; wvalid = 1'b1;
    bus3 = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge c125);
      act_cs[i] = lcd_cs_n;
      act_wr[i] = lcd_wr_n;
      if (i == 3) bus3 = {lcd_dc, lcd_d};
      exp_cs[i] = !(i >= 2 && i < 2 + int'(CMD_SPAN));
      exp_wr[i] = !(i >= 3 && i < 3 + int'(WR_LOW));
      @(posedge c125); #1;
      if (i == 0) wvalid = 1'b0;
    end
    n_checks++;
    if (act_cs !== exp_cs) begin
      n_fails++;
      $display("FAIL cmd_cs_timing: got %b want %b (bit i = cycle N+i)", act_cs, exp_cs);
    end
    n_checks++;
    if (act_wr !== exp_wr) begin
      n_fails++;
      $display("FAIL cmd_wr_timing: got %b want %b (bit i = cycle N+i)", act_wr, exp_wr);
    end
    n_checks++;
    if (bus3 !== {1'b0, 16'h002C}) begin
      n_fails++;
      $display("FAIL cmd_bus: got dc/d=%h want 0002c", bus3);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok || cap_q.size() != 1) begin
      n_fails++;
      $display("FAIL cmd_strobe_count: got %0d (idle=%0b) want 1", cap_q.size(), ok);
    end
  endtask

  task automatic test_pix();
    bit ok;
    flush_capture();
    wr(AW'(ADDR_PIX), 32'hF800_07E0);
    wait_idle(ok);
    n_checks++;
    if (!ok || cap_q.size() != 2) begin
      n_fails++;
      $display("FAIL pix_count: got %0d strobes (idle=%0b) want 2", cap_q.size(), ok);
    end else begin
      n_checks++;
      if (cap_q[0] !== {1'b1, 16'hF800} || cap_q[1] !== {1'b1, 16'h07E0}) begin
        n_fails++;
        $display("FAIL pix_data: got %h %h want 1f800 107e0", cap_q[0], cap_q[1]);
      end
      n_checks++;
      if (lo_q[0] != WR_LOW || lo_q[1] != WR_LOW || hi_q[1] != WR_HIGH) begin
        n_fails++;
        $display("FAIL pix_timing: got lo=%0d,%0d gap=%0d want lo=%0d gap=%0d",
                 lo_q[0], lo_q[1], hi_q[1], WR_LOW, WR_HIGH);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] act_cs, exp_cs, act_dc, exp_dc;
    bit ok;
    logic [31:0] pd;
    flush_capture();
    pd = $urandom;
    act_cs = '0; exp_cs = '0; act_dc = '0; exp_dc = '0;
    addr = AW'(ADDR_CMD); wdata = 32'h0000_002A; wvalid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge c125);
      if (i >= 2) begin
        act_cs[i] = lcd_cs_n;
        exp_cs[i] = (i >= 2 + int'(CMD_SPAN + PIX_PERIOD));
      end
      if (i >= 2 && i < 2 + int'(CMD_SPAN + PIX_PERIOD)) begin
        act_dc[i] = lcd_dc;
        exp_dc[i] = (i >= 2 + int'(CMD_SPAN));
      end
      @(posedge c125); #1;
      if (i == 0) begin
        addr = AW'(ADDR_PIX); wdata = pd;
      end
      if (i == 1) wvalid = 1'b0;
    end
    n_checks++;
    if (act_cs !== exp_cs) begin
      n_fails++;
      $display("FAIL b2b_cs: got %b want %b", act_cs, exp_cs);
    end
    n_checks++;
    if (act_dc !== exp_dc) begin
      n_fails++;
      $display("FAIL b2b_dc: got %b want %b", act_dc, exp_dc);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok || cap_q.size() != 3 || cap_q[0] !== 17'h0002A || cap_q[1] !== {1'b1, pd[31:16]} ||
        cap_q[2] !== {1'b1, pd[15:0]}) begin
      n_fails++;
      $display("FAIL b2b_words: got %0d strobes, first %h want 3: 0002a %h %h",
               cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : 17'h0,
               {1'b1, pd[31:16]}, {1'b1, pd[15:0]});
    end
  endtask

  task automatic test_random_stream();
    logic [16:0] exp_q[$];
    logic [31:0] d, st;
    int unsigned r;
    logic m_rst, m_bl;
    bit ok;
    flush_capture();
    wr(AW'(ADDR_CTRL), 32'h3);
    m_rst = 1'b1; m_bl = 1'b1;
    for (int k = 0; k < 12; k++) begin
      r = $urandom_range(0, 9);
      d = $urandom;
      if (r < 4) begin
        wr(AW'(ADDR_CMD), d);
        exp_q.push_back({1'b0, 8'h00, d[7:0]});
      end else if (r < 7) begin
        wr(AW'(ADDR_PIX), d);
        exp_q.push_back({1'b1, d[31:16]});
        exp_q.push_back({1'b1, d[15:0]});
      end else if (r == 7) begin
        wr(AW'(ADDR_CTRL), d);
        m_rst = d[0]; m_bl = d[1];
      end else if (r == 8) begin
        wr(AW'(ADDR_STATUS), d);
      end else begin
        wr(AW'($urandom_range(4, 255)), d);
      end
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle(ok);
    n_checks++;
    if (!ok || cap_q.size() != exp_q.size()) begin
      n_fails++;
      $display("FAIL rand_count: got %0d strobes (idle=%0b) want %0d", cap_q.size(), ok, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (cap_q[i] !== exp_q[i] || lo_q[i] != WR_LOW) begin
          n_fails++;
          $display("FAIL rand_word[%0d]: got %h lo=%0d want %h lo=%0d", i, cap_q[i], lo_q[i],
                   exp_q[i], WR_LOW);
        end
      end
    end
    rd(AW'(ADDR_CTRL), st);
    n_checks++;
    if (st !== {30'b0, m_bl, m_rst} || lcd_rst_n !== m_rst || lcd_bl !== m_bl) begin
      n_fails++;
      $display("FAIL rand_ctrl: got %h rst_n=%b bl=%b want bl=%b rst_n=%b", st, lcd_rst_n, lcd_bl,
               m_bl, m_rst);
    end
  endtask

  task automatic test_overflow();
    logic [16:0] exp_q[$];
    logic [31:0] d, st;
    int cnt, free_at, acc, nw;
    bit ovf, pop_now, take, ok;
    flush_capture();
    cnt = 0; free_at = 0; acc = 0; ovf = 1'b0;
    nw = $urandom_range(18, 24);
    // Drain-rate model: one PIX entry leaves every PIX_PERIOD cycles once the queue is busy.
    for (int c = 0; c < nw; c++) begin
      d = $urandom;
      pop_now = (cnt > 0) && (c >= free_at);
      if (pop_now) free_at = c + int'(PIX_PERIOD);
      take = (cnt < int'(DEPTH)) || pop_now;
      if (take) begin
        acc++;
        exp_q.push_back({1'b1, d[31:16]});
        exp_q.push_back({1'b1, d[15:0]});
      end else begin
        ovf = 1'b1;
      end
      cnt = cnt + int'(take) - int'(pop_now);
      addr = AW'(ADDR_PIX); wdata = d; wvalid = 1'b1;
      tick();
    end
    wvalid = 1'b0;
    rd(AW'(ADDR_STATUS), st);
    n_checks++;
    if (st !== {ovf, 1'b1, 24'b0, 6'(cnt)}) begin
      n_fails++;
      $display("FAIL ovf_status: got %h want %h (writes=%0d)", st, {ovf, 1'b1, 24'b0, 6'(cnt)}, nw);
    end
    wr(AW'(ADDR_CTRL), 32'h8000_0003);
    rd(AW'(ADDR_STATUS), st);
    n_checks++;
    if (st[31] !== 1'b0 || st[30] !== 1'b1) begin
      n_fails++;
      $display("FAIL ovf_clear: got overflow=%b busy=%b want 0 1", st[31], st[30]);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok || cap_q.size() != 2 * acc) begin
      n_fails++;
      $display("FAIL ovf_strobes: got %0d (idle=%0b) want %0d", cap_q.size(), ok, 2 * acc);
    end else begin
      n_checks++;
      ok = 1'b1;
      foreach (exp_q[i]) if (cap_q[i] !== exp_q[i]) ok = 1'b0;
      if (!ok) begin
        n_fails++;
        $display("FAIL ovf_order: got first %h last %h want %h %h", cap_q[0], cap_q[cap_q.size()-1],
                 exp_q[0], exp_q[exp_q.size()-1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] st;
    bit seen;
    int n;
    flush_capture();
    wr(AW'(ADDR_CTRL), 32'h3);
    for (int k = 0; k < 4; k++) wr(AW'(ADDR_CMD), $urandom);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge c125);
      if (!lcd_wr_n) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fails++;
      $display("FAIL rstmid_no_strobe: got no lcd_wr_n low within 50 cycles want one");
    end
    #1 reset = 1'b1;
    @(posedge c125); #1;
    reset = 1'b0;
    n_checks++;
    if ({lcd_wr_n, lcd_cs_n, lcd_rst_n} !== 3'b110) begin
      n_fails++;
      $display("FAIL rstmid_pins: got wr_n=%b cs_n=%b rst_n=%b want 1 1 0", lcd_wr_n, lcd_cs_n,
               lcd_rst_n);
    end
    rd(AW'(ADDR_STATUS), st);
    n_checks++;
    if (st !== 32'h0) begin
      n_fails++;
      $display("FAIL rstmid_status: got %h want 00000000", st);
    end
    @(negedge c125);
    n = cap_q.size();
    repeat (40) tick();
    n_checks++;
    if (cap_q.size() != n || lcd_cs_n !== 1'b1) begin
      n_fails++;
      $display("FAIL rstmid_quiet: got %0d extra strobes cs_n=%b want 0 1", cap_q.size() - n, lcd_cs_n);
    end
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_cmd();
    test_pix();
    test_back_to_back();
    test_random_stream();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
